// File: rtl/rf_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_hazard_scoreboard
// Purpose  : Issue-side hazard scoreboard for the 8x16b bypassing register
//            file. It counts in-flight writes per register and stalls
//            conflicting issues.
// Option   : SB_WAW_STALL_EN - limits each register to one outstanding write.
// Revision : 1.0 - initial release
// ============================================================================
module rf_hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [2:0] issue_rs1,
    input  logic       issue_rs1_used,
    input  logic [2:0] issue_rs2,
    input  logic       issue_rs2_used,
    input  logic [2:0] issue_rd,
    input  logic       issue_rd_wr,
    input  logic       wb_en,
    input  logic [2:0] wb_sel,
    output logic       issue_stall,
    output logic       issue_accept,
    output logic [7:0] pending_vec,
    output logic       sb_err
);

    localparam int                 C_CNT_W   = 3;
    localparam logic [C_CNT_W-1:0] C_MAX_CNT = C_CNT_W'(MAX_INFLIGHT);
    localparam logic [C_CNT_W-1:0] C_ONE     = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_count [8];
    logic               r_sb_err;

    logic [C_CNT_W-1:0] w_rs1_cnt;
    logic [C_CNT_W-1:0] w_rs2_cnt;
    logic [C_CNT_W-1:0] w_rd_cnt;
    logic               w_rs1_haz;
    logic               w_rs2_haz;
    logic               w_rd_block;
    logic               w_stall;
    logic               w_accept;
    logic [7:0]         w_inc;
    logic [7:0]         w_wb_hit;
    logic [7:0]         w_underflow;

    assign w_rs1_cnt = r_count[issue_rs1];
    assign w_rs2_cnt = r_count[issue_rs2];
    assign w_rd_cnt  = r_count[issue_rd];

    // A writeback retiring the last pending write is forwarded by the RF.
    assign w_rs1_haz = issue_rs1_used && (w_rs1_cnt != '0) &&
                       !(wb_en && (wb_sel == issue_rs1) && (w_rs1_cnt == C_ONE));
    assign w_rs2_haz = issue_rs2_used && (w_rs2_cnt != '0) &&
                       !(wb_en && (wb_sel == issue_rs2) && (w_rs2_cnt == C_ONE));

`ifdef SB_WAW_STALL_EN
    assign w_rd_block = issue_rd_wr && (w_rd_cnt != '0);
`else
    assign w_rd_block = issue_rd_wr && (w_rd_cnt == C_MAX_CNT);
`endif

    assign w_stall      = issue_valid && (!rst || w_rs1_haz || w_rs2_haz || w_rd_block);
    assign w_accept     = issue_valid && !w_stall;
    assign issue_stall  = w_stall;
    assign issue_accept = w_accept;
    assign sb_err       = r_sb_err;

    for (genvar gi = 0; gi < 8; gi++) begin : g_reg
        assign w_inc[gi]       = w_accept && issue_rd_wr && (issue_rd == 3'(gi));
        assign w_wb_hit[gi]    = wb_en && (wb_sel == 3'(gi));
        // Same-cycle issue and writeback on an empty register cancel out.
        assign w_underflow[gi] = w_wb_hit[gi] && !w_inc[gi] && (r_count[gi] == '0);
        assign pending_vec[gi] = (r_count[gi] != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_inc[i] && !w_wb_hit[i]) begin
                    r_count[i] <= r_count[i] + C_ONE;
                end else if (w_wb_hit[i] && !w_inc[i] && (r_count[i] != '0)) begin
                    r_count[i] <= r_count[i] - C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb_err <= 1'b0;
        end else if (|w_underflow) begin
            r_sb_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_hazard_scoreboard
// Purpose  : Directed-vector bench for rf_hazard_scoreboard. Expected outputs
//            are queued per cycle and compared by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_hazard_scoreboard;

`ifdef SB_WAW_STALL_EN
    localparam bit WAW = 1'b1;
`else
    localparam bit WAW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [2:0] issue_rs1;
    logic       issue_rs1_used;
    logic [2:0] issue_rs2;
    logic       issue_rs2_used;
    logic [2:0] issue_rd;
    logic       issue_rd_wr;
    logic       wb_en;
    logic [2:0] wb_sel;
    logic       issue_stall;
    logic       issue_accept;
    logic [7:0] pending_vec;
    logic       sb_err;

    typedef struct {
        string      name;
        logic       stall;
        logic       accept;
        logic [7:0] pend;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rf_hazard_scoreboard #(.MAX_INFLIGHT(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2      (issue_rs2),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_wr    (issue_rd_wr),
        .wb_en          (wb_en),
        .wb_sel         (wb_sel),
        .issue_stall    (issue_stall),
        .issue_accept   (issue_accept),
        .pending_vec    (pending_vec),
        .sb_err         (sb_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s.%s got=0x%0h want=0x%0h", name, field, got, want);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "stall",  int'(issue_stall),  int'(e.stall));
            cmp(e.name, "accept", int'(issue_accept), int'(e.accept));
            cmp(e.name, "pend",   int'(pending_vec),  int'(e.pend));
            cmp(e.name, "err",    int'(sb_err),       int'(e.err));
        end
    end

    task automatic step(input string name, input logic r, input logic v,
                        input logic [2:0] rs1, input logic u1,
                        input logic [2:0] rs2, input logic u2,
                        input logic [2:0] rd, input logic wr,
                        input logic wb, input logic [2:0] ws,
                        input logic es, input logic ea,
                        input logic [7:0] ep, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; issue_valid = v;
        issue_rs1 = rs1; issue_rs1_used = u1;
        issue_rs2 = rs2; issue_rs2_used = u2;
        issue_rd = rd; issue_rd_wr = wr;
        wb_en = wb; wb_sel = ws;
        e.name = name; e.stall = es; e.accept = ea; e.pend = ep; e.err = ee;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; issue_valid = 1'b0;
        issue_rs1 = '0; issue_rs1_used = 1'b0;
        issue_rs2 = '0; issue_rs2_used = 1'b0;
        issue_rd = '0; issue_rd_wr = 1'b0;
        wb_en = 1'b0; wb_sel = '0;

        //   name          rst v  rs1 u1 rs2 u2 rd wr wb ws  stall acc  pend   err
        step("rst_hold0",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1,    0,   8'h00, 0);
        step("rst_hold1",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1,    0,   8'h00, 0);
        step("idle",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0,    1,   8'h00, 0);
        step("raw_issue",  1, 1, 0, 0, 0, 0, 3, 1, 0, 0,  0,    1,   8'h00, 0);
        step("raw_stall",  1, 1, 3, 1, 0, 0, 0, 0, 0, 0,  1,    0,   8'h08, 0);
        step("raw_bypass", 1, 1, 3, 1, 0, 0, 0, 0, 1, 3,  0,    1,   8'h08, 0);
        step("raw_clear",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,    0,   8'h00, 0);
`ifndef SB_WAW_STALL_EN
        step("sat_1",      1, 1, 0, 0, 0, 0, 5, 1, 0, 0,  0,    1,   8'h00, 0);
        step("sat_2",      1, 1, 0, 0, 0, 0, 5, 1, 0, 0,  0,    1,   8'h20, 0);
        step("sat_3",      1, 1, 0, 0, 0, 0, 5, 1, 0, 0,  0,    1,   8'h20, 0);
        step("sat_full",   1, 1, 0, 0, 0, 0, 5, 1, 0, 0,  1,    0,   8'h20, 0);
        step("sat_full_wb",1, 1, 0, 0, 0, 0, 5, 1, 1, 5,  1,    0,   8'h20, 0);
        step("sat_accept", 1, 1, 0, 0, 0, 0, 5, 1, 0, 0,  0,    1,   8'h20, 0);
        step("rs2_stall",  1, 1, 0, 0, 5, 1, 0, 0, 1, 5,  1,    0,   8'h20, 0);
        step("drain5_a",   1, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0,    0,   8'h20, 0);
        step("drain5_b",   1, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0,    0,   8'h20, 0);
        step("sim_set",    1, 1, 0, 0, 0, 0, 2, 1, 0, 0,  0,    1,   8'h00, 0);
        step("sim_both",   1, 1, 0, 0, 0, 0, 2, 1, 1, 2,  0,    1,   8'h04, 0);
        step("sim_hold",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,    0,   8'h04, 0);
        step("drain2",     1, 0, 0, 0, 0, 0, 0, 0, 1, 2,  0,    0,   8'h04, 0);
`endif
        step("uf_wb6",     1, 0, 0, 0, 0, 0, 0, 0, 1, 6,  0,    0,   8'h00, 0);
        step("uf_sticky",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,    0,   8'h00, 1);
        step("empty_both", 1, 1, 0, 0, 0, 0, 6, 1, 1, 6,  0,    1,   8'h00, 1);
        step("empty_chk",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,    0,   8'h00, 1);
        step("r0_issue",   1, 1, 0, 0, 0, 0, 0, 1, 0, 0,  0,    1,   8'h00, 1);
        step("r0_raw",     1, 1, 0, 0, 0, 1, 0, 0, 0, 0,  1,    0,   8'h01, 1);
        step("waw_1",      1, 1, 0, 0, 0, 0, 4, 1, 0, 0,  0,    1,   8'h01, 1);
        step("waw_2",      1, 1, 0, 0, 0, 0, 4, 1, 0, 0,  WAW,  !WAW, 8'h11, 1);
        step("r1_a",       1, 1, 0, 0, 0, 0, 1, 1, 0, 0,  0,    1,   8'h11, 1);
        step("r1_b",       1, 1, 0, 0, 0, 0, 1, 1, 0, 0,  WAW,  !WAW, 8'h13, 1);
        // Reset asserted mid-cycle must clear state before the next edge.
        step("async_rst",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1,    0,   8'h00, 0);
        step("post_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,    0,   8'h00, 0);
        step("stale_wb",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0,    0,   8'h00, 0);
        step("stale_err",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,    0,   8'h00, 1);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue_left=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t want=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
